// File: rtl/prog_loader.sv
// Instruction-memory loader: receives framed bytes, assembles MSB-first words into
// a small instruction RAM and releases the processor reset after a checksum-verified load.
module prog_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned IW    = 32,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  localparam int unsigned BPW = IW / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CW  = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WR, S_CHK, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   wptr_q, wptr_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [IW-1:0]   word_q, word_d;
  logic [7:0]      xsum_q, xsum_d;
  logic            done_d, err_d, cpu_rst_d, s_ready_d;
  logic            mem_we;
  logic            xfer, hdr_hit, len_ok, last_word;
  logic [IW-1:0]   mem [DEPTH];

  assign xfer      = s_valid && s_ready;
  assign hdr_hit   = xfer && (s_data == HDR);
  assign len_ok    = (s_data != 8'd0) && (s_data <= 8'(DEPTH));
  assign last_word = ((wptr_q + CW'(1)) == len_q);

  // State register
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (hdr_hit) state_nxt = S_LEN;
      S_LEN:          if (xfer) state_nxt = len_ok ? S_DATA : S_IDLE;
      S_DATA:         if (xfer && (bcnt_q == BCW'(BPW - 1))) state_nxt = S_WR;
      S_WR:           state_nxt = last_word ? S_CHK : S_DATA;
      S_CHK:          if (xfer) state_nxt = (s_data == xsum_q) ? S_DONE : S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Next values for flags and datapath registers
  always_comb begin
    done_d    = done;
    err_d     = err;
    cpu_rst_d = cpu_rst;
    len_d     = len_q;
    wptr_d    = wptr_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    xsum_d    = xsum_q;
    mem_we    = 1'b0;
    s_ready_d = (state_nxt != S_WR);
    case (state)
      S_IDLE, S_DONE: begin
        if (hdr_hit) begin
          err_d     = 1'b0;
          done_d    = 1'b0;
          cpu_rst_d = 1'b1;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (len_ok) begin
            len_d  = CW'(s_data);
            wptr_d = '0;
            bcnt_d = '0;
            xsum_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[IW-9:0], s_data};
          xsum_d = xsum_q ^ s_data;
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      S_WR: begin
        mem_we = 1'b1;
        wptr_d = wptr_q + CW'(1);
        bcnt_d = '0;
      end
      S_CHK: begin
        if (xfer) begin
          if (s_data == xsum_q) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      done    <= 1'b0;
      err     <= 1'b0;
      cpu_rst <= 1'b1;
      s_ready <= 1'b1;
      len_q   <= '0;
      wptr_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      xsum_q  <= '0;
    end else begin
      done    <= done_d;
      err     <= err_d;
      cpu_rst <= cpu_rst_d;
      s_ready <= s_ready_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      xsum_q  <= xsum_d;
    end
  end

  // Instruction RAM: contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[AW-1:0]] <= word_q;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames plus random frames checked against a
// frame-level parser model of the loader.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        sys_rst, s_valid, s_ready, cpu_rst, done, err;
  logic [7:0]  s_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;
  int nrdy_total = 0;
  int r0;

  logic [31:0] m_mem [16];
  bit          m_known [16];
  bit          m_done, m_err, m_cpu;
  logic [7:0]  q [$];

  prog_loader dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sys_rst && !s_ready) nrdy_total++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: walk the byte stream the way the frame format defines it
  function automatic void model_feed(input logic [7:0] b[$]);
    int i = 0;
    int n;
    logic [7:0]  x;
    while (i < b.size()) begin
      if (b[i] != 8'hA5) begin i++; continue; end
      m_err = 0; m_done = 0; m_cpu = 1; i++;
      if (i >= b.size()) return;
      n = int'(b[i]); i++;
      if (n < 1 || n > 16) begin m_err = 1; continue; end
      x = 8'h00;
      for (int w = 0; w < n; w++) begin
        if (i + 4 > b.size()) return;
        m_mem[w]   = {b[i], b[i+1], b[i+2], b[i+3]};
        m_known[w] = 1'b1;
        x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
        i += 4;
      end
      if (i >= b.size()) return;
      if (b[i] == x) begin m_done = 1; m_cpu = 0; end
      else m_err = 1;
      i++;
    end
  endfunction

  function automatic void model_reset();
    m_done = 0; m_err = 0; m_cpu = 1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit sent = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        s_valid = 1'b0; s_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1; s_data = b;
    for (int i = 0; i < 16 && !sent; i++) begin
      @(negedge clk);
      if (s_ready) sent = 1'b1;
      @(posedge clk); #1;
    end
    if (!sent) chk("byte_accept_timeout", 32'(sent), 32'd1);
    s_valid = 1'b0; s_data = 8'($urandom);
  endtask

  task automatic send_seq(input logic [7:0] b[$], input bit gaps);
    foreach (b[k]) send_byte(b[k], gaps);
    model_feed(b);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(m_cpu));
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      if (m_known[a]) begin
        rd_addr = 4'(a); #1;
        chk($sformatf("%s_mem%0d", tag, a), rd_data, m_mem[a]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic build_frame(input int n, input bit good, output logic [7:0] b[$]);
    logic [7:0] x = 8'h00;
    logic [7:0] d;
    b = {};
    b.push_back(8'hA5);
    b.push_back(8'(n));
    for (int k = 0; k < 4 * n; k++) begin
      d = 8'($urandom);
      b.push_back(d);
      x = x ^ d;
    end
    b.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  initial begin
    logic [7:0] g;
    sys_rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; rd_addr = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_flags("in_reset");
    sys_rst = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_data = 8'($urandom);
      check_flags("t1");
    end
    @(posedge clk); #1;

    // 2: two-word frame
    q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    r0 = nrdy_total;
    send_seq(q, 1'b0);
    chk("t2_ready_low_cycles", 32'(nrdy_total - r0), 32'd2);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_cpu_rst", 32'(cpu_rst), 32'd0);
    check_flags("t2");
    rd_addr = 4'd1; #1;
    chk("t2_rd1", rd_data, 32'h55667788);
    rd_addr = 4'd0; #1;
    chk("t2_rd0", rd_data, 32'h11223344);
    check_mem("t2");

    // 3: bad checksum, then good frame
    q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    send_seq(q, 1'b0);
    chk("t3_err", 32'(err), 32'd1);
    check_flags("t3_bad");
    build_frame(3, 1'b1, q);
    send_seq(q, 1'b0);
    check_flags("t3_good");
    check_mem("t3");

    // 4: illegal lengths and ignored bytes
    q = '{8'hA5, 8'h00};
    send_seq(q, 1'b0);
    check_flags("t4_len0");
    q = '{8'hA5, 8'h11};
    send_seq(q, 1'b0);
    check_flags("t4_len17");
    q = '{8'h00, 8'hFF};
    send_seq(q, 1'b0);
    chk("t4_err_sticky", 32'(err), 32'd1);
    check_flags("t4_garbage");

    // 5: garbage then gapped single-word frame
    q = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_seq(q, 1'b1);
    rd_addr = 4'd0; #1;
    chk("t5_rd0", rd_data, 32'hDEADBEEF);
    chk("t5_done", 32'(done), 32'd1);
    check_flags("t5");
    check_mem("t5");

    // 6a: asynchronous reset from the loaded state
    #2 sys_rst = 1'b0;
    #1;
    model_reset();
    chk("t6a_cpu_rst_async", 32'(cpu_rst), 32'd1);
    chk("t6a_done_async", 32'(done), 32'd0);
    @(negedge clk); sys_rst = 1'b1;
    @(posedge clk); #1;

    // 6b: reset mid-frame, then retransmit
    build_frame(2, 1'b1, q);
    begin
      logic [7:0] part [$];
      part = q[0:7];
      send_seq(part, 1'b0);
    end
    sys_rst = 1'b0; #1;
    model_reset();
    chk("t6b_cpu_rst_async", 32'(cpu_rst), 32'd1);
    chk("t6b_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk); sys_rst = 1'b1;
    @(posedge clk); #1;
    check_flags("t6b_after_rst");
    check_mem("t6b_partial");
    send_seq(q, 1'b0);
    chk("t6b_done_final", 32'(done), 32'd1);
    check_flags("t6b_full");
    check_mem("t6b_full");

    // Random frames with random garbage and gaps
    for (int f = 0; f < 8; f++) begin
      logic [7:0] pre [$];
      pre = {};
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        pre.push_back(g);
      end
      send_seq(pre, 1'b1);
      build_frame(int'($urandom_range(1, 16)), ($urandom % 4) != 0, q);
      send_seq(q, 1'b1);
      check_flags($sformatf("rnd%0d", f));
      check_mem($sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer-side counterpart to the processor's instruction fetch.
- Receives a framed byte stream over a valid/ready interface.
- Assembles 32-bit instruction words, MSB first, into a 16-entry instruction memory.
- Exposes an asynchronous read port for the processor's fetch, and holds the processor in reset (cpu_rst) until a load completes with a valid checksum.

Parameters:
- DEPTH, 16, number of 32-bit instruction words.
- AW, 4, address width (log2 DEPTH).
- IW, 32, instruction word width; must be a multiple of 8.
- HDR, 8'hA5, frame header byte.

Ports:
- clk, in, 1, system clock; all state updates on rising edge.
- sys_rst, in, 1, asynchronous active-low reset.
- s_valid, in, 1, byte valid from the host link.
- s_data, in, 8, byte payload.
- s_ready, out, 1, loader can accept a byte; a byte transfers when s_valid && s_ready at a clk edge.
- rd_addr, in, AW, processor fetch address.
- rd_data, out, IW, combinational read: mem[rd_addr].
- cpu_rst, out, 1, active-high reset to the processor; 1 whenever no valid image is present.
- done, out, 1, valid image loaded.
- err, out, 1, last frame rejected; sticky until the next accepted header.

Behaviour:

Frame format:
- HDR, then N (1..DEPTH), then N*IW/8 data bytes (MSB first per word), then CHK.
- CHK = XOR of all data bytes. Header and N are excluded from CHK.

Reset (sys_rst=0, asynchronous):
- state=IDLE, cpu_rst=1, done=0, err=0, s_ready=1.
- Word count, byte count, shift register and running XOR are cleared.
- Memory contents are not reset.
- Reset mid-frame discards the partial word; words already written remain but stay gated by cpu_rst=1.

States:
- IDLE (s_ready=1): a byte == HDR moves to LEN, sets err<=0, done<=0, cpu_rst<=1. Other bytes are discarded with no flag change.
- LEN (s_ready=1): accepted byte n. If 1 <= n <= DEPTH: latch N, clear wptr and XOR, go to DATA. Otherwise err<=1, go to IDLE.
- DATA (s_ready=1): each accepted byte shifts in as word = {word[IW-9:0], byte] and XOR ^= byte. On the (IW/8)th byte of a word, go to WR.
- WR (s_ready=0, exactly one cycle): mem[wptr] <= word; wptr++. If wptr+1 == N go to CHK, else DATA. The byte counter is cleared.
- CHK (s_ready=1): accepted byte equals XOR → DONE with done<=1, cpu_rst<=0. Mismatch → err<=1, IDLE; cpu_rst stays 1.
- DONE (s_ready=1): done=1, cpu_rst=0. An accepted HDR byte moves to LEN and reasserts cpu_rst=1 and clears done on the same edge. Non-header bytes are ignored.

Other rules:
- Memory is written only in WR; the write is visible on rd_data the following cycle.
- Words at addresses >= N keep their prior contents.
- s_valid may drop at any time. With no transfer there is no state change and counters hold.
- s_data is ignored when no transfer occurs.
- Flags (done, err, cpu_rst) are registered; none combinational from inputs.
- Reset has priority over all other events.

Test Plan:
1. Release sys_rst with s_valid=0 → cpu_rst=1, done=0, err=0, s_ready=1; hold 10 cycles with no change.
2. Send A5 02 11 22 33 44 55 66 77 88 88 → mem[0]=32'h11223344, mem[1]=32'h55667788; s_ready=0 for exactly 2 cycles (one after byte 0x44, one after 0x88); done=1 and cpu_rst=0 one cycle after CHK is accepted; rd_addr=1 gives 32'h55667788.
3. Same frame with CHK=00 → err=1, done=0, cpu_rst=1. A following correct frame then clears err and ends with done=1.
4. Send A5 00, then A5 11 → err=1 after each, state returns to IDLE; next bytes 00 FF are ignored with err still 1.
5. Send bytes 00 FF 3C, then a valid N=1 frame with random s_valid gaps (A5 01 DE AD BE EF, CHK=22) → mem[0]=32'hDEADBEEF, done=1; garbage bytes had no effect.
6. Assert sys_rst for 1 cycle after 6 data bytes of an N=2 frame → cpu_rst=1 immediately (asynchronous), done=0. Retransmit the full frame → load completes correctly.
